// File: rtl/decision_trail_stack.sv
// DPLL assignment trail: push/pop stack of (var, val, decision, flipped) entries
// with a hardware chronological backtrack. Define TRAIL_WATERMARK_EN to build the max_count high-water mark.
module decision_trail_stack #(
  parameter int MAX_VARS = 64,
  parameter int VAR_BITS = $clog2(MAX_VARS),
  parameter int DEPTH    = MAX_VARS,
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  logic [VAR_BITS-1:0] push_var,
  input  logic                push_val,
  input  logic                push_dec,
  input  logic                pop,
  input  logic                bt_start,
  output logic                top_valid,
  output logic [VAR_BITS-1:0] top_var,
  output logic                top_val,
  output logic                top_dec,
  output logic                top_flipped,
  output logic [CNT_BITS-1:0] count,
  output logic [CNT_BITS-1:0] level,
  output logic                empty,
  output logic                full,
  output logic                bt_busy,
  output logic                unassign_valid,
  output logic [VAR_BITS-1:0] unassign_var,
  output logic                bt_done,
  output logic [VAR_BITS-1:0] bt_var,
  output logic                bt_val,
  output logic                unsat,
  output logic                overflow,
  output logic [CNT_BITS-1:0] max_count
);

  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state, state_next;

  logic [VAR_BITS-1:0] var_mem  [DEPTH];
  logic                val_mem  [DEPTH];
  logic                dec_mem  [DEPTH];
  logic                flip_mem [DEPTH];

  logic [IDX_BITS-1:0] top_idx, wr_idx;
  logic                wr_en, flip_en;
  logic [CNT_BITS-1:0] count_next, level_next;
  logic                ovf_set, unsat_next, done_next;

  assign top_idx     = IDX_BITS'(count - ONE);
  assign top_valid   = (count != '0);
  assign top_var     = top_valid ? var_mem[top_idx]  : '0;
  assign top_val     = top_valid ? val_mem[top_idx]  : 1'b0;
  assign top_dec     = top_valid ? dec_mem[top_idx]  : 1'b0;
  assign top_flipped = top_valid ? flip_mem[top_idx] : 1'b0;
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign bt_busy     = (state == SCAN);
  assign unassign_var = unassign_valid ? top_var : '0;

  always_comb begin
    state_next     = state;
    wr_en          = 1'b0;
    wr_idx         = IDX_BITS'(count);
    flip_en        = 1'b0;
    count_next     = count;
    level_next     = level;
    ovf_set        = 1'b0;
    unsat_next     = 1'b0;
    done_next      = 1'b0;
    unassign_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bt_start) begin
          if (empty) unsat_next = 1'b1;
          else       state_next = SCAN;
        end else if (push && pop && !empty) begin
          wr_en      = 1'b1;
          wr_idx     = top_idx;
          level_next = level + CNT_BITS'(push_dec) - CNT_BITS'(top_dec);
        end else if (push) begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            wr_en      = 1'b1;
            count_next = count + ONE;
            level_next = level + CNT_BITS'(push_dec);
          end
        end else if (pop && !empty) begin
          count_next = count - ONE;
          level_next = level - CNT_BITS'(top_dec);
        end
      end
      SCAN: begin
        // Implied and already-flipped entries are discarded; the first unflipped decision is flipped in place.
        if (!top_dec || top_flipped) begin
          unassign_valid = 1'b1;
          count_next     = count - ONE;
          level_next     = level - CNT_BITS'(top_dec);
          if (count == ONE) begin
            unsat_next = 1'b1;
            state_next = IDLE;
          end
        end else begin
          flip_en    = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      level    <= '0;
      overflow <= 1'b0;
      unsat    <= 1'b0;
      bt_done  <= 1'b0;
      bt_var   <= '0;
      bt_val   <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      level    <= level_next;
      overflow <= overflow | ovf_set;
      unsat    <= unsat_next;
      bt_done  <= done_next;
      if (done_next) begin
        bt_var <= top_var;
        bt_val <= ~top_val;
      end
    end
  end

  // Storage is never reset; count alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      var_mem[wr_idx]  <= push_var;
      val_mem[wr_idx]  <= push_val;
      dec_mem[wr_idx]  <= push_dec;
      flip_mem[wr_idx] <= 1'b0;
    end else if (flip_en) begin
      val_mem[top_idx]  <= ~val_mem[top_idx];
      flip_mem[top_idx] <= 1'b1;
    end
  end

`ifdef TRAIL_WATERMARK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              max_count <= '0;
    else if (count > max_count) max_count <= count;
  end
`else
  assign max_count = '0;
`endif

endmodule

// File: tb/tb_decision_trail_stack.sv
// Self-checking bench for decision_trail_stack (DEPTH=4, 16 variables); scoreboard queue of expected unassign variables.
module tb_decision_trail_stack;

  localparam int VB = 4;
  localparam int CB = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          push = 1'b0, push_val = 1'b0, push_dec = 1'b0, pop = 1'b0, bt_start = 1'b0;
  logic [VB-1:0] push_var = '0;
  logic          top_valid, top_val, top_dec, top_flipped, empty, full, bt_busy;
  logic          unassign_valid, bt_done, bt_val, unsat, overflow;
  logic [VB-1:0] top_var, unassign_var, bt_var;
  logic [CB-1:0] count, level, max_count;

  int checks = 0;
  int failures = 0;
  int exp_ua[$];

  decision_trail_stack #(.MAX_VARS(16), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .push(push), .push_var(push_var), .push_val(push_val),
    .push_dec(push_dec), .pop(pop), .bt_start(bt_start), .top_valid(top_valid), .top_var(top_var),
    .top_val(top_val), .top_dec(top_dec), .top_flipped(top_flipped), .count(count), .level(level),
    .empty(empty), .full(full), .bt_busy(bt_busy), .unassign_valid(unassign_valid),
    .unassign_var(unassign_var), .bt_done(bt_done), .bt_var(bt_var), .bt_val(bt_val),
    .unsat(unsat), .overflow(overflow), .max_count(max_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_entry(input logic [VB-1:0] v, input logic val, input logic dec);
    push = 1'b1; push_var = v; push_val = val; push_dec = dec;
    step();
    push = 1'b0;
  endtask

  task automatic pop_entry();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (count !== 3'd0 || level !== 3'd0) begin failures++; $display("[TB] FAIL reset_cnt: count=%0d level=%0d expected 0 0", count, level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || top_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags: empty=%b full=%b top_valid=%b expected 1 0 0", empty, full, top_valid); end
    checks++; if ({overflow, bt_busy, bt_done, unsat, unassign_valid} !== 5'b0 || max_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_strobes: %b max=%0d expected 00000 0", {overflow, bt_busy, bt_done, unsat, unassign_valid}, max_count); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_watermark();
    int exp_max;
    push_entry(4'd1, 1'b0, 1'b1);
    push_entry(4'd2, 1'b0, 1'b0);
    push_entry(4'd3, 1'b1, 1'b0);
    pop_entry();
    pop_entry();
    step();
`ifdef TRAIL_WATERMARK_EN
    exp_max = 3;
`else
    exp_max = 0;
`endif
    checks++; if (max_count !== CB'(exp_max)) begin failures++; $display("[TB] FAIL watermark: max_count=%0d expected %0d", max_count, exp_max); end
    checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL watermark_cnt: count=%0d expected 1", count); end
  endtask

  task automatic test_push();
    push_entry(4'd5, 1'b1, 1'b1);
    push_entry(4'd9, 1'b0, 1'b0);
    push_entry(4'd3, 1'b1, 1'b0);
    checks++; if (count !== 3'd3 || level !== 3'd1) begin failures++; $display("[TB] FAIL push_cnt: count=%0d level=%0d expected 3 1", count, level); end
    checks++; if (top_var !== 4'd3 || top_dec !== 1'b0 || top_val !== 1'b1 || top_flipped !== 1'b0) begin failures++; $display("[TB] FAIL push_top: var=%0d dec=%b val=%b flip=%b expected 3 0 1 0", top_var, top_dec, top_val, top_flipped); end
  endtask

  task automatic test_backtrack();
    int done_c = 0, n_done = 0, n_unsat = 0, last_ua = 0;
    logic busy1 = 1'b0;
    exp_ua.push_back(3);
    exp_ua.push_back(9);
    bt_start = 1'b1;
    step();
    bt_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) busy1 = bt_busy;
      if (unassign_valid) begin
        checks++;
        if (exp_ua.size() == 0) begin failures++; $display("[TB] FAIL bt_unexpected_ua: var=%0d expected none", unassign_var); end
        else begin
          int e = exp_ua.pop_front();
          if (unassign_var !== VB'(e)) begin failures++; $display("[TB] FAIL bt_ua_var: got %0d expected %0d", unassign_var, e); end
        end
        last_ua = c;
      end
      if (bt_done) begin n_done++; done_c = c; end
      if (unsat) n_unsat++;
      step();
    end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL bt_busy: got %b expected 1", busy1); end
    checks++; if (exp_ua.size() != 0 || last_ua != 2) begin failures++; $display("[TB] FAIL bt_ua_count: left=%0d last_cycle=%0d expected 0 2", exp_ua.size(), last_ua); exp_ua.delete(); end
    checks++; if (n_done != 1 || done_c != 4 || n_unsat != 0) begin failures++; $display("[TB] FAIL bt_done_timing: pulses=%0d cycle=%0d unsat=%0d expected 1 4 0", n_done, done_c, n_unsat); end
    checks++; if (bt_var !== 4'd5 || bt_val !== 1'b0) begin failures++; $display("[TB] FAIL bt_result: var=%0d val=%b expected 5 0", bt_var, bt_val); end
    checks++; if (count !== 3'd1 || level !== 3'd1 || top_flipped !== 1'b1 || top_val !== 1'b0 || bt_busy !== 1'b0) begin failures++; $display("[TB] FAIL bt_trail: count=%0d level=%0d flip=%b val=%b busy=%b expected 1 1 1 0 0", count, level, top_flipped, top_val, bt_busy); end
  endtask

  task automatic test_unsat();
    int unsat_c = 0, n_done = 0, n_unsat = 0;
    exp_ua.push_back(5);
    bt_start = 1'b1;
    step();
    bt_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (unassign_valid) begin
        checks++;
        if (exp_ua.size() == 0) begin failures++; $display("[TB] FAIL unsat_unexpected_ua: var=%0d expected none", unassign_var); end
        else begin
          int e = exp_ua.pop_front();
          if (unassign_var !== VB'(e)) begin failures++; $display("[TB] FAIL unsat_ua_var: got %0d expected %0d", unassign_var, e); end
        end
      end
      if (bt_done) n_done++;
      if (unsat) begin n_unsat++; unsat_c = c; end
      step();
    end
    checks++; if (exp_ua.size() != 0) begin failures++; $display("[TB] FAIL unsat_ua_missing: left=%0d expected 0", exp_ua.size()); exp_ua.delete(); end
    checks++; if (n_unsat != 1 || unsat_c != 2 || n_done != 0) begin failures++; $display("[TB] FAIL unsat_pulse: pulses=%0d cycle=%0d done=%0d expected 1 2 0", n_unsat, unsat_c, n_done); end
    checks++; if (count !== 3'd0 || level !== 3'd0 || empty !== 1'b1 || bt_var !== 4'd5) begin failures++; $display("[TB] FAIL unsat_trail: count=%0d level=%0d empty=%b bt_var=%0d expected 0 0 1 5", count, level, empty, bt_var); end
  endtask

  task automatic test_overflow();
    push_entry(4'd1, 1'b1, 1'b1);
    push_entry(4'd2, 1'b0, 1'b1);
    push_entry(4'd3, 1'b1, 1'b0);
    push_entry(4'd4, 1'b0, 1'b1);
    checks++; if (full !== 1'b1 || overflow !== 1'b0 || count !== 3'd4) begin failures++; $display("[TB] FAIL full_4th: full=%b ovf=%b count=%0d expected 1 0 4", full, overflow, count); end
    push_entry(4'd6, 1'b1, 1'b1);
    checks++; if (overflow !== 1'b1 || count !== 3'd4 || level !== 3'd3 || top_var !== 4'd4) begin failures++; $display("[TB] FAIL overflow: ovf=%b count=%0d level=%0d top=%0d expected 1 4 3 4", overflow, count, level, top_var); end
    pop_entry();
    pop_entry();
    checks++; if (full !== 1'b0 || overflow !== 1'b1 || count !== 3'd2 || level !== 3'd2) begin failures++; $display("[TB] FAIL ovf_sticky: full=%b ovf=%b count=%0d level=%0d expected 0 1 2 2", full, overflow, count, level); end
  endtask

  task automatic test_push_pop();
    push = 1'b1; pop = 1'b1; push_var = 4'd7; push_val = 1'b1; push_dec = 1'b0;
    step();
    push = 1'b0; pop = 1'b0;
    checks++; if (count !== 3'd2 || level !== 3'd1) begin failures++; $display("[TB] FAIL replace_cnt: count=%0d level=%0d expected 2 1", count, level); end
    checks++; if (top_var !== 4'd7 || top_dec !== 1'b0 || top_val !== 1'b1 || top_flipped !== 1'b0) begin failures++; $display("[TB] FAIL replace_top: var=%0d dec=%b val=%b flip=%b expected 7 0 1 0", top_var, top_dec, top_val, top_flipped); end
    pop_entry();
    checks++; if (top_var !== 4'd1 || level !== 3'd1) begin failures++; $display("[TB] FAIL pop_after_replace: top=%0d level=%0d expected 1 1", top_var, level); end
    pop_entry();
    pop_entry();
    checks++; if (count !== 3'd0 || level !== 3'd0 || empty !== 1'b1 || top_var !== 4'd0 || top_valid !== 1'b0) begin failures++; $display("[TB] FAIL pop_empty: count=%0d level=%0d empty=%b top=%0d valid=%b expected 0 0 1 0 0", count, level, empty, top_var, top_valid); end
  endtask

  task automatic test_reset_mid_scan();
    int n_done = 0, n_unsat = 0;
    int exp_max;
`ifdef TRAIL_WATERMARK_EN
    exp_max = 4;
`else
    exp_max = 0;
`endif
    checks++; if (max_count !== CB'(exp_max)) begin failures++; $display("[TB] FAIL watermark_peak: max_count=%0d expected %0d", max_count, exp_max); end
    push_entry(4'd2, 1'b1, 1'b1);
    push_entry(4'd4, 1'b0, 1'b0);
    push_entry(4'd6, 1'b1, 1'b0);
    push_entry(4'd8, 1'b0, 1'b0);
    bt_start = 1'b1;
    step();
    bt_start = 1'b0;
    checks++; if (bt_busy !== 1'b1 || unassign_valid !== 1'b1 || unassign_var !== 4'd8) begin failures++; $display("[TB] FAIL scan_enter: busy=%b ua=%b var=%0d expected 1 1 8", bt_busy, unassign_valid, unassign_var); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bt_busy !== 1'b0 || unassign_valid !== 1'b0 || count !== 3'd0 || level !== 3'd0 || empty !== 1'b1) begin failures++; $display("[TB] FAIL async_reset: busy=%b ua=%b count=%0d level=%0d empty=%b expected 0 0 0 0 1", bt_busy, unassign_valid, count, level, empty); end
    checks++; if (overflow !== 1'b0 || top_valid !== 1'b0 || max_count !== 3'd0 || bt_var !== 4'd0) begin failures++; $display("[TB] FAIL async_reset_regs: ovf=%b valid=%b max=%0d bt_var=%0d expected 0 0 0 0", overflow, top_valid, max_count, bt_var); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bt_done) n_done++;
      if (unsat) n_unsat++;
      step();
    end
    checks++; if (n_done != 0 || n_unsat != 0 || bt_busy !== 1'b0 || count !== 3'd0) begin failures++; $display("[TB] FAIL post_reset: done=%0d unsat=%0d busy=%b count=%0d expected 0 0 0 0", n_done, n_unsat, bt_busy, count); end
  endtask

  initial begin
    test_reset();
    test_watermark();
    test_reset();
    test_push();
    test_backtrack();
    test_unsat();
    test_overflow();
    test_push_pop();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decision_trail_stack.md
Name: decision_trail_stack

Overview:
- Parametrised successor to the decider's index stack: a full DPLL assignment trail.
- Each entry holds a variable index, its assigned value, a decision/implied flag and a flipped flag.
- Supports single push/pop and a hardware chronological backtrack. The backtrack pops implied and already-flipped entries, streams their variables out for unassignment, then flips the most recent unflipped decision in place.
- Sits between the Decider/BCP units and control; control uses bt_done/unsat to resume deciding or terminate.

Parameters:
- MAX_VARS, 64: number of variables; the variable index range is 0..MAX_VARS-1.
- VAR_BITS, $clog2(MAX_VARS): variable index width.
- DEPTH, MAX_VARS: number of trail entries.
- CNT_BITS, $clog2(DEPTH+1): width of the count and level outputs.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- push  in  1  push an entry (IDLE only).
- push_var  in  VAR_BITS  variable index to push.
- push_val  in  1  assigned value.
- push_dec  in  1  1 = decision, 0 = implied.
- pop  in  1  pop the top entry (IDLE only).
- bt_start  in  1  begin backtrack (IDLE only).
- top_valid  out  1  trail non-empty.
- top_var  out  VAR_BITS  top entry variable; 0 when empty.
- top_val  out  1  top entry value; 0 when empty.
- top_dec  out  1  top entry decision flag; 0 when empty.
- top_flipped  out  1  top entry flipped flag; 0 when empty.
- count  out  CNT_BITS  number of entries.
- level  out  CNT_BITS  number of decision entries (flipped or not) on the trail.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- bt_busy  out  1  FSM in SCAN.
- unassign_valid  out  1  one-cycle strobe: unassign_var was popped this cycle.
- unassign_var  out  VAR_BITS  variable popped during backtrack.
- bt_done  out  1  one-cycle pulse: decision flipped.
- bt_var  out  VAR_BITS  flipped decision variable (held until next bt_done).
- bt_val  out  1  new (inverted) value of bt_var (held).
- unsat  out  1  one-cycle pulse: backtrack exhausted the trail.
- overflow  out  1  sticky: push attempted while full.
- max_count  out  CNT_BITS  high-water mark (optional feature).

Behaviour:
- Reset (async, reset_n=0):
  - count=0, level=0, empty=1, full=0.
  - All strobes and flags 0, bt_var/bt_val=0, max_count=0, FSM=IDLE.
  - Storage contents are don't-care.
  - Reset during SCAN aborts the backtrack immediately; no bt_done or unsat is issued.
- top_* outputs are combinational from storage[count-1].
- FSM states: IDLE, SCAN.
- In IDLE, priority is bt_start > push/pop. All updates are visible the next cycle.
  - push only, not full: write the entry with flipped=0; count+1; level+push_dec.
  - push only, full: entry dropped, overflow<=1.
  - pop only, not empty: count-1; level-top_dec. Pop does not drive unassign_valid.
  - pop only, empty: ignored.
  - push && pop, not empty: top replaced in place; count unchanged; level adjusted by push_dec-top_dec.
  - push && pop, empty: treated as push.
  - bt_start, empty: unsat pulses next cycle; stays IDLE.
  - bt_start, not empty: go to SCAN; push and pop are ignored.
- SCAN, one top entry examined per cycle:
  - Implied entry, or decision with flipped=1: pop it; unassign_valid=1, unassign_var=var in the same cycle; level-1 if decision.
    - If count becomes 0: unsat pulses next cycle, then IDLE.
  - Unflipped decision: invert val in place and set flipped=1; not popped.
    - bt_done=1, bt_var=var, bt_val=new val, registered and visible next cycle. FSM returns to IDLE.
- Latency: with k entries above the target decision, unassign strobes appear in cycles 1..k after bt_start; bt_done appears in cycle k+2.
- bt_busy=1 for every cycle in SCAN.
- push, pop and bt_start asserted while bt_busy are ignored; they do not set overflow.
- count and level never wrap; overflow clears only on reset.

Optional Feature:
- TRAIL_WATERMARK_EN defined: max_count is updated every cycle to max(max_count, count) and cleared only on reset.
- TRAIL_WATERMARK_EN not defined: max_count is tied to 0 and no comparator or register is built.
- The port exists in both builds.

Test Plan:
- Reset, then push (5,1,dec), (9,0,imp), (3,1,imp) -> count=3, level=1, top_var=3, top_dec=0.
- Then bt_start:
  - unassign strobes: var 3, then var 9;
  - next: bt_done with bt_var=5, bt_val=0;
  - trail left as count=1, level=1, top_flipped=1.
- Repeat bt_start on that trail -> var 5 unassigned, count=0, level=0, unsat pulses once, no bt_done.
- DEPTH=4: push 5 entries -> full=1 after the 4th push, 5th push dropped, overflow=1 sticky, count=4.
- push+pop in the same cycle with count=2: pop a decision, push implied -> count=2, level-1, top replaced.
  - Also: pop on empty -> no change.
- Assert reset_n=0 mid-SCAN -> all outputs at reset values with no clock edge; after release, bt_done is never seen.
  - With TRAIL_WATERMARK_EN: push 3, pop 2 -> max_count=3.
